regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised integer register file with an integrated busy-bit scoreboard for the decode/dispatch stage of the CPU pipeline.
- Provides NUM_READ combinational read ports and NUM_WRITE synchronous write-back ports.
- Tracks per-register pending-writer state, raises an operand-ready flag for dispatch, and supports a pipeline flush that drops all reservations.
- Successor to the 2-read/1-write register file: adds async reset, per-port widths, multiple write ports, flush and optional write-to-read bypass.

Parameters:
- XLEN, cpu_parameters::xlen, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of 2, >= 2.
- NUM_READ, 2, number of read ports.
- NUM_WRITE, 1, number of write-back ports.
- AW, $clog2(NUM_REGS), register address width (derived; not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  NUM_WRITE  write-back enable per port
- w_ad  in  NUM_WRITE x AW  write-back register address
- w_data  in  NUM_WRITE x XLEN  write-back data
- r_valid  in  NUM_READ  read-port operand used
- r_ad  in  NUM_READ x AW  read address
- r_data  out  NUM_READ x XLEN  read data
- r_ready  out  1  all valid operands available
- rsv_valid  in  1  dispatch reserves destination register
- rsv_ad  in  AW  destination register to mark busy
- flush  in  1  clear all busy bits (mispredict / exception)
- busy  out  NUM_REGS  scoreboard state, for debug and hazard units

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers are 0 and all busy bits are 0.
  - r_data follows the reset contents (0); r_ready = 1.
- Register 0:
  - always reads 0 and is never busy.
  - writes and reservations to address 0 are ignored.
- Read:
  - purely combinational, zero latency.
  - r_data[i] = reg[r_ad[i]] regardless of r_valid[i]; no latches.
- r_ready = AND over i of (!r_valid[i] | !busy[r_ad[i]]).
  - With all r_valid low, r_ready = 1.
- Write:
  - at posedge, for each port with w_valid and w_ad != 0: reg[w_ad] <= w_data and busy[w_ad] <= 0.
  - Same address on several write ports in one cycle: the highest-indexed port wins.
- Reserve: at posedge, if rsv_valid and rsv_ad != 0 and !flush, busy[rsv_ad] <= 1.
- Reserve and write to the same register in the same cycle: reserve wins; busy ends at 1 and the data is updated.
- Flush:
  - at posedge, busy <= 0 for every register and that cycle's reservation is dropped.
  - Writes in the flush cycle still update register data.
- Reset asserted mid-operation discards all pending state immediately; no write completes after rst_n falls.
- Address range: an address >= NUM_REGS is impossible because NUM_REGS is a power of 2.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read data forwarding: when a w_valid port writes r_ad[i] (nonzero) in the current cycle, r_data[i] returns that port's w_data; the highest-indexed matching port wins.
  - Ready forwarding: that operand counts as not busy for r_ready in the same cycle.
  - Adds combinational paths from w_* to r_data and r_ready.
- Undefined: written data and the busy clear become visible the cycle after the write edge.

Decomposition:
- Shared in cpu_parameters: xlen, NUM_REGS default, typedef reg_addr_t (logic[AW-1:0]), typedef xword_t (logic[xlen-1:0]).
- One natural sub-module, regfile_busy_table: holds the busy-bit vector and its set, clear and flush logic, and computes r_ready.
- The data array and read muxes stay in the top module.

Test Plan:
- Reset check: assert rst_n low asynchronously between edges -> busy = 0 and r_data = 0 immediately; after release, r_ready = 1.
- Basic write/read: write 0xDEADBEEF to x5, then read r_ad[0] = 5 next cycle -> 0xDEADBEEF.
- Register 0 protection: write 0x1234 to x0 and reserve x0 -> reading x0 gives 0, busy[0] = 0.
- Scoreboard: reserve x7; next cycle r_valid[1] = 1, r_ad[1] = 7 -> r_ready = 0. Write x7 = 0x55 -> next cycle r_ready = 1 and data = 0x55. With REGFILE_BYPASS_EN defined, r_ready = 1 and data = 0x55 in the write cycle itself.
- Reserve and write same cycle on x3 -> busy[3] = 1 after the edge, reg[3] updated.
- Flush: reserve x1, x2, x9 over three cycles, then flush together with rsv x4 and w x2 = 0xA -> busy all 0, reg[2] = 0xA. With NUM_WRITE = 2, both ports writing x6 -> port 1's data retained.

Source files
------------

// File: rtl/cpu_parameters.sv
// cpu_parameters: shared CPU-wide widths and types used by the register file and its scoreboard.
`default_nettype none
package cpu_parameters;
    localparam int xlen     = 32;
    localparam int num_regs = 32;
    localparam int reg_aw   = $clog2(num_regs);

    typedef logic [reg_aw-1:0] reg_addr_t;
    typedef logic [xlen-1:0]   xword_t;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_busy_table.sv
// regfile_busy_table: per-register pending-writer bits with reserve/clear/flush and operand-ready output.
// Optional macro REGFILE_BYPASS_EN lets a same-cycle write-back clear an operand's busy state for o_ready.
`default_nettype none
module regfile_busy_table
    import cpu_parameters::*;
#(
    parameter  int NUM_REGS  = num_regs,
    parameter  int NUM_READ  = 2,
    parameter  int NUM_WRITE = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WRITE-1:0]           i_wr_valid,
    input  logic [NUM_WRITE-1:0][AW-1:0]   i_wr_ad,
    input  logic                           i_rsv_valid,
    input  logic [AW-1:0]                  i_rsv_ad,
    input  logic                           i_flush,
    input  logic [NUM_READ-1:0]            i_rd_valid,
    input  logic [NUM_READ-1:0][AW-1:0]    i_rd_ad,
    output logic                           o_ready,
    output logic [NUM_REGS-1:0]            o_busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] w_busy_eff;

    // Priority low to high: write clear, then reserve, then flush; x0 is forced idle last.
    always_comb begin
        w_wr_hit = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (i_wr_valid[p]) begin
                w_wr_hit[i_wr_ad[p]] = 1'b1;
            end
        end
        w_wr_hit[0] = 1'b0;
        w_busy_nxt  = r_busy & ~w_wr_hit;
        if (i_rsv_valid) begin
            w_busy_nxt[i_rsv_ad] = 1'b1;
        end
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_wr_hit;
`else
    assign w_busy_eff = r_busy;
`endif

    always_comb begin
        o_ready = 1'b1;
        for (int i = 0; i < NUM_READ; i++) begin
            if (i_rd_valid[i] && w_busy_eff[i_rd_ad[i]]) begin
                o_ready = 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port integer register file with busy-bit scoreboard and flush.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data/ready to the read ports.
`default_nettype none
module regfile_scoreboard
    import cpu_parameters::*;
#(
    parameter  int XLEN      = xlen,
    parameter  int NUM_REGS  = num_regs,
    parameter  int NUM_READ  = 2,
    parameter  int NUM_WRITE = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WRITE-1:0]            w_valid,
    input  logic [NUM_WRITE-1:0][AW-1:0]    w_ad,
    input  logic [NUM_WRITE-1:0][XLEN-1:0]  w_data,
    input  logic [NUM_READ-1:0]             r_valid,
    input  logic [NUM_READ-1:0][AW-1:0]     r_ad,
    output logic [NUM_READ-1:0][XLEN-1:0]   r_data,
    output logic                            r_ready,
    input  logic                            rsv_valid,
    input  logic [AW-1:0]                   rsv_ad,
    input  logic                            flush,
    output logic [NUM_REGS-1:0]             busy
);
    logic [XLEN-1:0] r_mem [NUM_REGS];

    // x0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (w_valid[p] && (w_ad[p] != '0)) begin
                    r_mem[w_ad[p]] <= w_data[p];
                end
            end
        end
    end

    always_comb begin
        r_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            r_data[i] = r_mem[r_ad[i]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (w_valid[p] && (w_ad[p] == r_ad[i]) && (r_ad[i] != '0)) begin
                    r_data[i] = w_data[p];
                end
            end
`endif
        end
    end

    regfile_busy_table #(
        .NUM_REGS  (NUM_REGS),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE)
    ) u_busy_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_valid  (w_valid),
        .i_wr_ad     (w_ad),
        .i_rsv_valid (rsv_valid),
        .i_rsv_ad    (rsv_ad),
        .i_flush     (flush),
        .i_rd_valid  (r_valid),
        .i_rd_ad     (r_ad),
        .o_ready     (r_ready),
        .o_busy      (busy)
    );
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of regfile_scoreboard against a behavioural model.
`default_nettype none
module tb_regfile_scoreboard;
    import cpu_parameters::*;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NG = 32;
    localparam int AW = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NW-1:0]           w_valid;
    logic [NW-1:0][AW-1:0]   w_ad;
    logic [NW-1:0][31:0]     w_data;
    logic [NR-1:0]           r_valid;
    logic [NR-1:0][AW-1:0]   r_ad;
    logic [NR-1:0][31:0]     r_data;
    logic                    r_ready;
    logic                    rsv_valid;
    logic [AW-1:0]           rsv_ad;
    logic                    flush;
    logic [NG-1:0]           busy;

    xword_t       m_reg [NG];
    logic [NG-1:0] m_busy;
    int           total = 0;
    int           bad   = 0;
    bit           chk_en = 1'b0;

    regfile_scoreboard #(
        .XLEN(32), .NUM_REGS(NG), .NUM_READ(NR), .NUM_WRITE(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_ad(w_ad), .w_data(w_data),
        .r_valid(r_valid), .r_ad(r_ad), .r_data(r_data), .r_ready(r_ready),
        .rsv_valid(rsv_valid), .rsv_ad(rsv_ad), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state after each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NG; k++) m_reg[k] <= '0;
            m_busy <= '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (w_valid[p] && w_ad[p] != 0) begin
                    m_reg[w_ad[p]]  <= w_data[p];
                    m_busy[w_ad[p]] <= 1'b0;
                end
            end
            if (flush) m_busy <= '0;
            else if (rsv_valid && rsv_ad != 0) m_busy[rsv_ad] <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic bit written_now(logic [AW-1:0] ad);
        for (int p = 0; p < NW; p++)
            if (w_valid[p] && w_ad[p] == ad && ad != 0) return 1'b1;
        return 1'b0;
    endfunction
`endif

    function automatic logic [31:0] exp_rd(int i);
        logic [31:0] v;
        if (r_ad[i] == 0) return 32'd0;
        v = m_reg[r_ad[i]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (w_valid[p] && w_ad[p] == r_ad[i]) v = w_data[p];
`endif
        return v;
    endfunction

    function automatic logic exp_ready();
        for (int i = 0; i < NR; i++) begin
            if (r_valid[i] && m_busy[r_ad[i]]) begin
`ifdef REGFILE_BYPASS_EN
                if (!written_now(r_ad[i])) return 1'b0;
`else
                return 1'b0;
`endif
            end
        end
        return 1'b1;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        for (int i = 0; i < NR; i++) check($sformatf("model r_data[%0d]", i), r_data[i], exp_rd(i));
        check("model r_ready", {31'd0, r_ready}, {31'd0, exp_ready()});
        check("model busy", busy, m_busy);
    endtask

    // One clock: compare on the falling edge, then move to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        if (chk_en) cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_valid = '0; w_ad = '0; w_data = '0;
        rsv_valid = 1'b0; rsv_ad = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        r_valid = '0; r_ad = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset busy", busy, 32'd0);
        check("reset ready", {31'd0, r_ready}, 32'd1);

        w_valid = 2'b01; w_ad[0] = 5'd5; w_data[0] = 32'hDEADBEEF; r_ad[0] = 5'd5;
        cyc(); idle(); #1;
        check("x5 read", r_data[0], 32'hDEADBEEF);

        w_valid = 2'b01; w_ad[0] = 5'd0; w_data[0] = 32'h1234; rsv_valid = 1'b1; rsv_ad = 5'd0;
        cyc(); idle(); r_ad[0] = 5'd0; #1;
        check("x0 read", r_data[0], 32'd0);
        check("x0 busy", {31'd0, busy[0]}, 32'd0);

        rsv_valid = 1'b1; rsv_ad = 5'd7;
        cyc(); idle(); r_valid = 2'b10; r_ad[1] = 5'd7; #1;
        check("x7 busy", {31'd0, busy[7]}, 32'd1);
        check("x7 not ready", {31'd0, r_ready}, 32'd0);
        w_valid = 2'b01; w_ad[0] = 5'd7; w_data[0] = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
        check("x7 fwd ready", {31'd0, r_ready}, 32'd1);
        check("x7 fwd data", r_data[1], 32'h55);
`else
        check("x7 write-cycle ready", {31'd0, r_ready}, 32'd0);
`endif
        cyc(); idle(); #1;
        check("x7 ready", {31'd0, r_ready}, 32'd1);
        check("x7 data", r_data[1], 32'h55);

        r_valid = '0;
        rsv_valid = 1'b1; rsv_ad = 5'd3; w_valid = 2'b10; w_ad[1] = 5'd3; w_data[1] = 32'h33;
        cyc(); idle(); r_ad[0] = 5'd3; #1;
        check("x3 rsv wins", {31'd0, busy[3]}, 32'd1);
        check("x3 data", r_data[0], 32'h33);

        rsv_valid = 1'b1; rsv_ad = 5'd1; cyc();
        rsv_ad = 5'd2; cyc();
        rsv_ad = 5'd9; cyc();
        idle(); #1;
        check("busy before flush", busy, 32'h0000_020E);
        flush = 1'b1; rsv_valid = 1'b1; rsv_ad = 5'd4;
        w_valid = 2'b01; w_ad[0] = 5'd2; w_data[0] = 32'hA;
        cyc(); idle(); r_ad[0] = 5'd2; #1;
        check("flush busy", busy, 32'd0);
        check("flush write x2", r_data[0], 32'hA);

        w_valid = 2'b11; w_ad[0] = 5'd6; w_ad[1] = 5'd6; w_data[0] = 32'h111; w_data[1] = 32'h222;
        cyc(); idle(); r_ad[1] = 5'd6; #1;
        check("x6 port1 wins", r_data[1], 32'h222);

        rsv_valid = 1'b1; rsv_ad = 5'd8;
        cyc(); idle(); r_ad[0] = 5'd5; #1;
        check("x8 busy", {31'd0, busy[8]}, 32'd1);
        rst_n = 1'b0; #1;
        check("async rst busy", busy, 32'd0);
        check("async rst data", r_data[0], 32'd0);
        cyc();
        rst_n = 1'b1; r_valid = 2'b11; r_ad[0] = 5'd5; r_ad[1] = 5'd8; #1;
        check("post rst ready", {31'd0, r_ready}, 32'd1);
        check("post rst data", r_data[0], 32'd0);

        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NW; p++) begin
                w_ad[p]   = 5'($urandom_range(0, 15));
                w_data[p] = $urandom;
            end
            w_valid   = 2'($urandom);
            r_valid   = 2'($urandom);
            for (int i = 0; i < NR; i++) r_ad[i] = 5'($urandom_range(0, 15));
            rsv_valid = 1'($urandom);
            rsv_ad    = 5'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 7) == 0);
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
